// File: rtl/nes_pad_poller_if.sv
// Pad-side pins plus the published button frame of nes_pad_poller.
// master = the poller, slave = whatever drives the pads and consumes buttons.
interface nes_pad_poller_if #(
    parameter int NUM_PADS = 2
);
    logic                  enable;
    logic [NUM_PADS-1:0]   nes_data;
    logic                  nes_latch;
    logic                  nes_clk;
    logic [8*NUM_PADS-1:0] buttons;
    logic                  valid;
    logic [8*NUM_PADS-1:0] pressed;
    logic [1:0]            fsm_state;

    // valid is a one-cycle strobe with no ready: buttons and pressed are
    // meaningful on the valid cycle, buttons then holds until the next frame.
    modport master (
        input  enable, nes_data,
        output nes_latch, nes_clk, buttons, valid, pressed, fsm_state
    );
    modport slave (
        output enable, nes_data,
        input  nes_latch, nes_clk, buttons, valid, pressed, fsm_state
    );
endinterface

// File: rtl/nes_pad_poller.sv
// Multi-pad NES controller poller: shared latch/clock, parallel serial capture.
// Optional macro NES_PRESS_EDGE_EN builds the rising-edge "pressed" flags.
module nes_pad_poller #(
    parameter int NUM_PADS    = 2,
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 250000
) (
    input  logic              clk,
    input  logic              reset,
    nes_pad_poller_if.master  bus
);
    localparam int SLOT = 2 * CLK_DIV;
    localparam int PW   = $clog2(POLL_PERIOD) + 1;
    localparam int DW   = $clog2(SLOT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [PW-1:0]         poll_cnt, poll_n;
    logic [DW-1:0]         div_cnt, div_n;
    logic [2:0]            bit_cnt, bit_n;
    logic [8*NUM_PADS-1:0] shreg, sh_n;
    logic [NUM_PADS-1:0]   sync1, sync2;
    logic                  div_last;
    logic                  latch_n, clk_n, valid_n;

    assign bus.fsm_state = state;
    assign div_last      = (div_cnt == DW'(SLOT - 1));

    // Pads idle high (released buttons), so the synchroniser resets to ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.nes_data;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        poll_n  = poll_cnt;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        case (state)
            IDLE: begin
                if (!bus.enable) begin
                    poll_n = '0;
                end else if (poll_cnt == PW'(POLL_PERIOD - 1)) begin
                    state_n = LATCH;
                    poll_n  = '0;
                    div_n   = '0;
                end else begin
                    poll_n = poll_cnt + PW'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    bit_n   = '0;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            SHIFT: begin
                if (div_last) begin
                    // First bit read lands in bit 0 after eight right shifts.
                    for (int p = 0; p < NUM_PADS; p++) begin
                        sh_n[8*p +: 8] = {~sync2[p], shreg[8*p+1 +: 7]};
                    end
                    div_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = DONE;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                poll_n  = '0;
                bit_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state.
    always_comb begin
        latch_n = (state_n == LATCH);
        clk_n   = (state_n == SHIFT) && (bit_n != 3'd0) && (div_n < DW'(CLK_DIV));
        valid_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            poll_cnt      <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.nes_latch <= 1'b0;
            bus.nes_clk   <= 1'b0;
            bus.valid     <= 1'b0;
            bus.buttons   <= '0;
        end else begin
            state         <= state_n;
            poll_cnt      <= poll_n;
            div_cnt       <= div_n;
            bit_cnt       <= bit_n;
            shreg         <= sh_n;
            bus.nes_latch <= latch_n;
            bus.nes_clk   <= clk_n;
            bus.valid     <= valid_n;
            if (valid_n) begin
                bus.buttons <= sh_n;
            end
        end
    end

`ifdef NES_PRESS_EDGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pressed <= '0;
        end else if (valid_n) begin
            bus.pressed <= sh_n & ~bus.buttons;
        end else begin
            bus.pressed <= '0;
        end
    end
`else
    assign bus.pressed = '0;
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: behavioural pads, frame waveform checks and a
// valid-driven scoreboard of {pressed, buttons}.
module tb_nes_pad_poller;
    localparam int NUM_PADS = 2;
    localparam int CD       = 4;
    localparam int PP       = 100;
    localparam int SLOT     = 2 * CD;
    localparam int FRAME    = PP + 9 * SLOT + 1;

    logic clk;
    logic reset;
    nes_pad_poller_if #(.NUM_PADS(NUM_PADS)) bus ();

    nes_pad_poller #(
        .NUM_PADS(NUM_PADS), .CLK_DIV(CD), .POLL_PERIOD(PP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_check = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  pad_btn [NUM_PADS];
    logic        toggle_mode = 1'b0;
    logic [15:0] last_btn;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Expected frame: buttons, and pressed only when edge logic is built.
    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] b, p;
        pad_btn[0] = b0;
        pad_btn[1] = b1;
        b = {b1, b0};
`ifdef NES_PRESS_EDGE_EN
        p = b & ~last_btn;
`else
        p = 16'h0000;
`endif
        exp_q.push_back({p, b});
        last_btn = b;
    endtask

    // Pad driver: real pad behaviour, or exact-edge toggling around each sample.
    initial begin
        int n, idx;
        logic pl, pc;
        n = 0; idx = 8; pl = 1'b0; pc = 1'b0;
        bus.nes_data = '1;
        forever begin
            @(negedge clk);
            if (bus.nes_latch && !pl) n = 0;
            else n++;
            if (toggle_mode) begin
                for (int b = 0; b < 8; b++) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        if (n == SLOT * (b + 2) - 5) bus.nes_data[p] = ~pad_btn[p][b];
                        if (n == SLOT * (b + 2) - 2) bus.nes_data[p] = pad_btn[p][b];
                    end
                end
            end else begin
                if (bus.nes_latch) idx = 0;
                else if (bus.nes_clk && !pc) idx++;
                for (int p = 0; p < NUM_PADS; p++)
                    bus.nes_data[p] = (idx < 8) ? ~pad_btn[p][idx] : 1'b1;
            end
            pl = bus.nes_latch;
            pc = bus.nes_clk;
        end
    end

    // Monitor: pop on valid, pressed must be zero elsewhere.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.valid) begin
                    if (exp_q.size() == 0) begin
                        check("valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("buttons", {16'h0, bus.buttons}, {16'h0, e[15:0]});
                        check("pressed", {16'h0, bus.pressed}, {16'h0, e[31:16]});
                    end
                end else if (bus.pressed != 16'h0) begin
                    check("pressed_idle", {16'h0, bus.pressed}, 32'h0);
                end
            end
        end
    end

    // Walk one frame from its first IDLE cycle, comparing latch/clk/valid.
    task automatic run_frame(input int drop_en_at, input int abort_at);
        int errs, first, s;
        logic el, ec, ev;
        errs = 0; first = -1;
        for (int o = 0; o < FRAME; o++) begin
            if (o == abort_at) break;
            if (o == drop_en_at) bus.enable = 1'b0;
            s  = o - PP - SLOT;
            el = (o >= PP) && (o < PP + SLOT);
            ec = (s >= 0) && (s < 8 * SLOT) && (s / SLOT >= 1) && (s % SLOT < CD);
            ev = (o == PP + 9 * SLOT);
            if (bus.nes_latch !== el || bus.nes_clk !== ec || bus.valid !== ev) begin
                if (first < 0) first = o;
                errs++;
            end
            @(negedge clk);
        end
        if (errs != 0)
            $display("FAIL frame_wave: %0d bad cycles (first at offset %0d), required 0", errs, first);
        n_check++;
        if (errs == 0) n_pass++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_latch"},   {31'h0, bus.nes_latch}, 32'h0);
        check({tag, "_clk"},     {31'h0, bus.nes_clk},   32'h0);
        check({tag, "_valid"},   {31'h0, bus.valid},     32'h0);
        check({tag, "_buttons"}, {16'h0, bus.buttons},   32'h0);
        check({tag, "_pressed"}, {16'h0, bus.pressed},   32'h0);
        check({tag, "_state"},   {30'h0, bus.fsm_state}, 32'h0);
    endtask

    initial begin
        int quiet_errs;
        reset = 1'b1;
        bus.enable = 1'b1;
        pad_btn[0] = 8'h00;
        pad_btn[1] = 8'h00;
        last_btn = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // disconnected pads, then consecutive-frame edge patterns
        push_frame(8'h00, 8'h00); run_frame(-1, -1);
        push_frame(8'h89, 8'h10); run_frame(-1, -1);
        push_frame(8'h01, 8'h00); run_frame(-1, -1);
        push_frame(8'h03, 8'h00); run_frame(-1, -1);
        push_frame(8'h03, 8'h00); run_frame(-1, -1);

        // enable dropped mid-shift: frame still publishes, then silence
        push_frame(8'h40, 8'h81); run_frame(130, -1);
        quiet_errs = 0;
        for (int i = 0; i < 3 * PP; i++) begin
            if (bus.nes_latch !== 1'b0 || bus.valid !== 1'b0) quiet_errs++;
            @(negedge clk);
        end
        check("disabled_quiet", quiet_errs, 0);

        // re-enable; data toggles just after each effective sample point
        bus.enable = 1'b1;
        toggle_mode = 1'b1;
        push_frame(8'hA5, 8'h3C); run_frame(-1, -1);
        toggle_mode = 1'b0;

        // reset while nes_clk is high mid-shift
        pad_btn[0] = 8'hFF;
        pad_btn[1] = 8'hFF;
        run_frame(-1, 140);
        check("pre_reset_clk", {31'h0, bus.nes_clk}, 32'h1);
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        last_btn = 16'h0000;
        push_frame(8'h22, 8'h44); run_frame(-1, -1);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule

// File: doc/nes_pad_poller.md
# nes_pad_poller

Parametrised multi-controller NES pad reader sitting between the bidirectional pad pins and the game datapath. It generates the shared latch and clock strobes and shifts in the serial data of up to four controllers in parallel. Each frame it publishes an active-high 8-bit button vector per pad, plus a one-cycle valid strobe. It replaces the per-side controller FSM/datapath pairs with one block that scales with pad count and poll rate.

## Interface
- NUM_PADS, 2, number of controllers read in parallel (1..4)
- CLK_DIV, 300, system clocks per half NES-clock period (≥2)
- POLL_PERIOD, 250000, idle clocks between frames (≥1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  polling enable; low means stop after the current frame
- nes_data  input  NUM_PADS  serial data from each pad, active-low, unsynchronised
- nes_latch  output  1  shared latch strobe to all pads
- nes_clk  output  1  shared shift clock to all pads
- buttons  output  8*NUM_PADS  registered button state, active-high; pad p occupies [8p+7:8p]
- valid  output  1  one-cycle pulse when buttons updates
- pressed  output  8*NUM_PADS  one-cycle rising-edge flags, coincident with valid

## Operation
- Each nes_data bit passes through a 2-flop synchroniser before use.
- FSM states are IDLE, LATCH, SHIFT and DONE.
- IDLE:
  - poll_cnt counts 0..POLL_PERIOD-1.
  - On the cycle with poll_cnt==POLL_PERIOD-1 and enable==1, go to LATCH.
  - If enable==0, hold poll_cnt at 0.
- LATCH:
  - nes_latch=1 for 2*CLK_DIV cycles, then go to SHIFT with bit_cnt=0.
- SHIFT:
  - 8 slots, bit_cnt 0..7, each 2*CLK_DIV cycles long; div_cnt counts 0..2*CLK_DIV-1.
  - For bit_cnt≥1, nes_clk=1 while div_cnt<CLK_DIV. Slot 0 has no clock pulse.
  - On the last cycle of each slot, shift ~sync_data[p] into shift register p (LSB-first fill).
  - After slot 7, go to DONE.
- DONE, one cycle:
  - buttons <= shift regs.
  - pressed <= new & ~old buttons.
  - valid=1.
  - Reset poll_cnt to 0 and go to IDLE.
- Bit order per pad: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- A disconnected pad (data pulled high) reads 8'h00.
- enable deasserted mid-frame: the frame completes and publishes normally, then the FSM stays in IDLE.
- pressed is zero on every cycle except DONE.
- Counter widths are $clog2 of their maximum value + 1. There is no wrap-around other than the explicit resets above.

## Timing
- Reset values: nes_latch=0, nes_clk=0, buttons=0, valid=0, pressed=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: latch and clock drop in the same instant (asynchronous), the partial shift data is discarded, and the block restarts from IDLE after release.
- Cycle n counts from the first rising edge after reset release, starting at n=0, with enable=1:
  - LATCH occupies cycles POLL_PERIOD .. POLL_PERIOD+2*CLK_DIV-1.
  - SHIFT follows for 16*CLK_DIV cycles.
  - valid is high at cycle POLL_PERIOD+18*CLK_DIV.
- Frame period = POLL_PERIOD+18*CLK_DIV+1 cycles.
- Data is sampled 2*CLK_DIV-1 cycles after the slot's clock rising edge, which is at least 3 cycles and covers the synchroniser delay.
- Outputs are registered with no combinational input-to-output path.

## Configuration
- NES_PRESS_EDGE_EN:
  - Defined: the pressed register and old-buttons compare are built as specified.
  - Undefined: pressed is tied to all zeros and no edge logic is synthesised; buttons and valid are unchanged.

## Test plan
- NUM_PADS=2, CLK_DIV=4, POLL_PERIOD=100, all data high -> latch high on cycles 100–107; nes_clk high for 4 cycles starting at cycles 116, 124, …, 164 (7 pulses); valid at cycle 172 with buttons=16'h0000; next latch at cycle 273.
- Pad 0 drives the A,Start,Right pattern (low on bits 0,3,7); pad 1 drives Up only -> buttons=16'h1089 at valid.
- Two consecutive frames with pad 0 = 8'h01 then 8'h03 -> second valid shows pressed[7:0]=8'h02; a third identical frame shows pressed=0. With the macro undefined, pressed stays 0 throughout.
- enable dropped at cycle 130 -> frame still completes with valid at 172; no latch afterwards; re-raising enable gives a latch POLL_PERIOD cycles later.
- reset asserted at cycle 140, mid-SHIFT -> nes_latch, nes_clk, buttons and valid all read 0 immediately; after release, the first latch comes at cycle 100 relative to release and no stale bits appear.
- Data toggling one cycle before each sample point, driven through the synchroniser -> sampled value equals the level held for at least 2 cycles before the sample.
